// File: rtl/ccff_chain_loader_if.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader_if
//   Bitstream word channel feeding the configuration-chain loader.
//   A word moves on every clock edge where cfg_valid and cfg_ready are both
//   high. The producer holds cfg_data stable while cfg_valid is high and
//   cfg_ready is low.
//
//   Signals:
//     cfg_data  [WORD_W-1:0]  bitstream word, bit 0 is shifted first
//     cfg_valid               cfg_data carries a word
//     cfg_ready               loader takes the word this cycle
//
//   Modports:
//     master  bitstream source (drives data/valid, observes ready)
//     slave   loader side      (observes data/valid, drives ready)
// ---------------------------------------------------------------------------
interface ccff_chain_loader_if #(
   parameter int WORD_W = 8
);
   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;

   modport master (
      output cfg_data,
      output cfg_valid,
      input  cfg_ready
   );

   modport slave (
      input  cfg_data,
      input  cfg_valid,
      output cfg_ready
   );
endinterface : ccff_chain_loader_if

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
//   Feeds a tile's configuration chain (ccff_head). Bitstream words arrive
//   over a valid/ready channel and are serialised LSB-first, one bit per
//   cycle. ccff_shift_en tells the external prog_clk gate that the chain must
//   capture ccff_head at the end of the cycle, so the chain only advances on
//   real data bits. After exactly CHAIN_LEN bits the loader pulses done.
//
//   Parameters:
//     CHAIN_LEN  total bits in the downstream chain (1..65535)
//     WORD_W     width of a bitstream word (1..32)
//
//   Ports:
//     prog_clk       configuration clock, rising edge
//     prog_reset     synchronous, active-high reset
//     start          begins a load when idle
//     abort          cancels an active load
//     cfg            word channel (slave side: cfg_data, cfg_valid, cfg_ready)
//     ccff_head      serial data into the chain (registered)
//     ccff_shift_en  chain captures ccff_head at the end of this cycle
//     ccff_tail      serial data returning from the chain's tail
//     busy           high while loading
//     done           one-cycle pulse when a load completes
//
//   Optional build macro CCFF_READBACK_CRC_EN adds:
//     wr_crc [15:0]  CRC-16-CCITT over every bit shifted into the chain
//     rb_crc [15:0]  same CRC over ccff_tail on the same cycles
//   Without the macro ccff_tail is not used.
// ---------------------------------------------------------------------------
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 1024,
   parameter int WORD_W    = 8
) (
   input  logic               prog_clk,
   input  logic               prog_reset,
   input  logic               start,
   input  logic               abort,
   ccff_chain_loader_if.slave cfg,
   output logic               ccff_head,
   output logic               ccff_shift_en,
   input  logic               ccff_tail,
   output logic               busy,
   output logic               done
`ifdef CCFF_READBACK_CRC_EN
   ,
   output logic [15:0]        wr_crc,
   output logic [15:0]        rb_crc
`endif
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int BC_W  = $clog2(WORD_W + 1);
   // Wide enough for any legal CHAIN_LEN; used for the "bits remaining" compare.
   localparam int CMP_W = 17;

   localparam logic [CNT_W-1:0] LEN_CNT   = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] FINAL_IDX = CNT_W'(CHAIN_LEN - 1);
   localparam logic [BC_W-1:0]  FULL_WORD = BC_W'(WORD_W);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q,    state_d;
   logic [CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;   // bits selected this load
   logic [WORD_W-1:0]  buf_q,      buf_d;       // word being serialised, next bit at [0]
   logic [BC_W-1:0]    buf_cnt_q,  buf_cnt_d;   // bits still to emit from buf_q
   logic               head_q,     head_d;
   logic               shift_en_q, shift_en_d;

   logic               emit;          // a bit is selected from the buffer this cycle
   logic               last_in_word;  // the selected bit is the last one used from buf_q
   logic [CMP_W-1:0]   bits_left;     // bits still owed to the chain, incl. this cycle's
   logic               ready;
   logic               take;

   // ------------------------------------------------------------------------
   // Handshake and bit selection
   // ------------------------------------------------------------------------
   always_comb begin
      emit         = (state_q == S_LOAD) && (buf_cnt_q != '0);
      // A partial final word ends at the chain's last bit, not at its MSB,
      // so the unused high bits are dropped with the buffer.
      last_in_word = emit && ((buf_cnt_q == BC_W'(1)) || (bit_cnt_q == FINAL_IDX));
      bits_left    = CMP_W'(CHAIN_LEN) - CMP_W'(bit_cnt_q);
      // Accept a word only into a free (or freeing) buffer, and only if the
      // chain still needs bits beyond those already buffered.
      ready        = (state_q == S_LOAD)
                     && ((buf_cnt_q == '0) || last_in_word)
                     && (bits_left > CMP_W'(buf_cnt_q));
      take         = ready && cfg.cfg_valid;
   end

   assign cfg.cfg_ready = ready;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   // NOTE: every variable gets a default before the case statement so no
   // path leaves it unassigned; that is what keeps this block latch-free.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      buf_d      = buf_q;
      buf_cnt_d  = buf_cnt_q;
      head_d     = head_q;       // head holds its value through starvation
      shift_en_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d   = S_LOAD;
               bit_cnt_d = '0;
               buf_cnt_d = '0;
            end
         end

         S_LOAD: begin
            if (abort) begin
               // Flush; anything selected this cycle is never shown.
               state_d   = S_IDLE;
               buf_cnt_d = '0;
            end else begin
               if (emit) begin
                  head_d     = buf_q[0];
                  shift_en_d = 1'b1;
                  bit_cnt_d  = bit_cnt_q + 1'b1;
                  buf_d      = buf_q >> 1;
                  buf_cnt_d  = last_in_word ? '0 : buf_cnt_q - 1'b1;
               end
               // take only happens when the buffer is empty or emptying, so
               // the new word cleanly replaces it with no bubble.
               if (take) begin
                  buf_d     = cfg.cfg_data;
                  buf_cnt_d = FULL_WORD;
               end
               // The last bit was selected last cycle and is on ccff_head now;
               // done follows in the next cycle.
               if (bit_cnt_q == LEN_CNT) begin
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         buf_cnt_q  <= '0;
         head_q     <= 1'b0;
         shift_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         buf_cnt_q  <= buf_cnt_d;
         head_q     <= head_d;
         shift_en_q <= shift_en_d;
      end
   end

   // NOTE: the word buffer payload is not reset; buf_cnt_q == 0 marks it
   // empty, so its contents are never observed before a word is loaded.
   always_ff @(posedge prog_clk) begin
      buf_q <= buf_d;
   end

   assign ccff_head     = head_q;
   assign ccff_shift_en = shift_en_q;
   assign busy          = (state_q == S_LOAD);
   assign done          = (state_q == S_DONE);

`ifdef CCFF_READBACK_CRC_EN
   // ------------------------------------------------------------------------
   // Readback CRC: bit-serial CRC-16-CCITT (poly 0x1021, init 0xFFFF).
   // wr_crc covers what goes into the chain; rb_crc covers what falls out of
   // its tail on the same cycles, i.e. the previous contents being displaced.
   // ------------------------------------------------------------------------
   function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   logic [15:0] wr_crc_q;
   logic [15:0] rb_crc_q;

   always_ff @(posedge prog_clk) begin
      if (prog_reset || ((state_q == S_IDLE) && (state_d == S_LOAD))) begin
         wr_crc_q <= 16'hFFFF;
         rb_crc_q <= 16'hFFFF;
      end else if (shift_en_q) begin
         wr_crc_q <= crc_step(wr_crc_q, head_q);
         rb_crc_q <= crc_step(rb_crc_q, ccff_tail);
      end
   end

   assign wr_crc = wr_crc_q;
   assign rb_crc = rb_crc_q;
`else
   // Tail data is only meaningful to the readback CRC.
   logic unused_tail;
   assign unused_tail = ccff_tail;
`endif

endmodule : ccff_chain_loader

// File: tb/tb_ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_chain_loader
//   Directed bench for ccff_chain_loader with CHAIN_LEN=20, WORD_W=8.
//   A behavioural model keeps a queue of (bit, due cycle) entries: every
//   accepted word schedules its used bits at acceptance+2, +3, ... and the
//   compare process checks ccff_shift_en, ccff_head, cfg_ready, busy and done
//   on every cycle. The chain itself is modelled as a 20-bit shift register
//   driving ccff_tail.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ccff_chain_loader;

   localparam int CHAIN_LEN = 20;
   localparam int WORD_W    = 8;

   logic prog_clk = 1'b0;
   logic prog_reset;
   logic start;
   logic abort;
   wire  ccff_head;
   wire  ccff_shift_en;
   wire  ccff_tail;
   wire  busy;
   wire  done;
`ifdef CCFF_READBACK_CRC_EN
   wire [15:0] wr_crc;
   wire [15:0] rb_crc;
`endif

   ccff_chain_loader_if #(.WORD_W(WORD_W)) cfg ();

   ccff_chain_loader #(
      .CHAIN_LEN(CHAIN_LEN),
      .WORD_W   (WORD_W)
   ) dut (
      .prog_clk     (prog_clk),
      .prog_reset   (prog_reset),
      .start        (start),
      .abort        (abort),
      .cfg          (cfg),
      .ccff_head    (ccff_head),
      .ccff_shift_en(ccff_shift_en),
      .ccff_tail    (ccff_tail),
      .busy         (busy),
      .done         (done)
`ifdef CCFF_READBACK_CRC_EN
      ,
      .wr_crc       (wr_crc),
      .rb_crc       (rb_crc)
`endif
   );

   always #5 prog_clk = ~prog_clk;

   // Downstream chain: advances only on gated clock edges.
   logic [CHAIN_LEN-1:0] chain = '0;
   always @(posedge prog_clk) begin
      if (ccff_shift_en === 1'b1) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
   end
   assign ccff_tail = chain[CHAIN_LEN-1];

   // ------------------------------------------------------------------------
   // Bookkeeping
   // ------------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
   endtask

   // Model state
   bit   armed    = 0;
   bit   active   = 0;     // model says the loader is in its load state
   int   pushed   = 0;     // bits requested from the word channel this load
   int   emitted  = 0;     // enabled bits seen this load
   int   done_cyc = -1;
   logic head_exp = 1'b0;
   bit   bit_q[$];
   int   due_q[$];
   bit   exp_en;
   bit   ready_exp;
   int   nb;

   // Per-load statistics read by the directed tests
   int          en_cnt   = 0;
   int          hs_cnt   = 0;
   int          done_cnt = 0;
   int          gap_cnt  = 0;
   logic [31:0] log_bits = '0;

   // ------------------------------------------------------------------------
   // Compare process: check this cycle's outputs, then advance the model by
   // what the coming edge will do.
   // ------------------------------------------------------------------------
   always @(negedge prog_clk) begin
      cyc++;
      ready_exp = 0;
      if (armed) begin
         exp_en = (due_q.size() > 0) && (due_q[0] == cyc);
         check("shift_en", ccff_shift_en, exp_en);
         if (exp_en) begin
            head_exp = bit_q.pop_front();
            void'(due_q.pop_front());
            emitted++;
            if (emitted == CHAIN_LEN) done_cyc = cyc + 1;
         end
         check("head", ccff_head, head_exp);
         check("done", done, (cyc == done_cyc));
         check("busy", busy, active);
         ready_exp = active && (pushed < CHAIN_LEN) && (due_q.size() <= 1);
         check("ready", cfg.cfg_ready, ready_exp);

         if (ccff_shift_en === 1'b1) begin
            if (en_cnt < 32) log_bits[en_cnt] = ccff_head;
            en_cnt++;
         end else if (active && en_cnt > 0 && en_cnt < CHAIN_LEN) begin
            gap_cnt++;
         end
         if (done === 1'b1) done_cnt++;
      end

      if (prog_reset) begin
         armed    = 1;
         active   = 0;
         head_exp = 1'b0;
         done_cyc = -1;
         bit_q.delete();
         due_q.delete();
      end else if (active) begin
         if (abort) begin
            active = 0;
            bit_q.delete();
            due_q.delete();
         end else begin
            if (cfg.cfg_valid && ready_exp) begin
               hs_cnt++;
               nb = (CHAIN_LEN - pushed < WORD_W) ? CHAIN_LEN - pushed : WORD_W;
               for (int i = 0; i < nb; i++) begin
                  bit_q.push_back(cfg.cfg_data[i]);
                  due_q.push_back(cyc + 2 + i);
               end
               pushed += nb;
            end
            if (emitted == CHAIN_LEN) active = 0;
         end
      end else if (armed && start && !abort && cyc != done_cyc) begin
         active   = 1;
         pushed   = 0;
         emitted  = 0;
         en_cnt   = 0;
         hs_cnt   = 0;
         done_cnt = 0;
         gap_cnt  = 0;
         log_bits = '0;
         bit_q.delete();
         due_q.delete();
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers (inputs change 1 ns after the rising edge)
   // ------------------------------------------------------------------------
   task automatic do_start(input int hold);
      @(posedge prog_clk); #1;
      start = 1'b1;
      repeat (hold) @(posedge prog_clk);
      #1;
      start = 1'b0;
   endtask

   // Offer one word; with gap>0, first wait until the loader asks for data and
   // then keep cfg_valid low for gap cycles.
   task automatic push_word(input logic [7:0] w, input int gap);
      int t;
      bit seen;
      if (gap > 0) begin
         t = 0; seen = 0;
         while (!seen && t < 200) begin
            @(negedge prog_clk); #1;
            seen = cfg.cfg_ready;
            t++;
         end
         repeat (gap) @(posedge prog_clk);
         #1;
      end
      cfg.cfg_data  = w;
      cfg.cfg_valid = 1'b1;
      t = 0; seen = 0;
      while (!seen && t < 200) begin
         @(negedge prog_clk); #1;
         seen = cfg.cfg_ready;
         t++;
      end
      check("push_accepted", seen, 1);
      @(posedge prog_clk); #1;
      cfg.cfg_valid = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      while (done_cnt == 0 && t < 100) begin
         @(negedge prog_clk); #1;
         t++;
      end
      check("done_seen", done_cnt, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge prog_clk);
      #1;
   endtask

   task automatic load3(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                        input int gap);
      do_start(1);
      push_word(w0, 0);
      push_word(w1, 0);
      push_word(w2, gap);
      wait_done();
   endtask

`ifdef CCFF_READBACK_CRC_EN
   function automatic logic [15:0] crc_model(input logic [31:0] bits, input int n);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         fb = c[15] ^ bits[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction
`endif

   // ------------------------------------------------------------------------
   // Directed tests
   // ------------------------------------------------------------------------
   initial begin
      prog_reset    = 1'b1;
      start         = 1'b0;
      abort         = 1'b0;
      cfg.cfg_valid = 1'b0;
      cfg.cfg_data  = '0;
      repeat (3) @(posedge prog_clk);
      #1;
      prog_reset = 1'b0;
      idle(1);
      check("rst_busy",  busy,          0);
      check("rst_done",  done,          0);
      check("rst_head",  ccff_head,     0);
      check("rst_en",    ccff_shift_en, 0);
      check("rst_ready", cfg.cfg_ready, 0);

      // Basic load plus partial final word: A5, 3C, then F6 of which only
      // the low nibble (0110) is used. Bits LSB-first pack to 20'h63CA5.
      // A start pulse during the DONE cycle must be ignored.
      do_start(1);
      push_word(8'hA5, 0);
      push_word(8'h3C, 0);
      push_word(8'hF6, 0);
      repeat (5) @(posedge prog_clk);
      #1;
      start = 1'b1;
      @(posedge prog_clk); #1;
      start = 1'b0;
      wait_done();
      idle(3);
      check("basic_bits",  log_bits[19:0], 20'h63CA5);
      check("basic_en",    en_cnt,   20);
      check("basic_hs",    hs_cnt,   3);
      check("basic_gap",   gap_cnt,  0);
      check("basic_done1", done_cnt, 1);
      check("basic_idle",  busy,     0);

      // Starvation: start held into the load (ignored), third word withheld
      // for 3 cycles once the loader asks for it. Low nibble of 5A is A.
      do_start(2);
      push_word(8'hA5, 0);
      push_word(8'h3C, 0);
      push_word(8'h5A, 3);
      wait_done();
      idle(2);
      check("starve_bits", log_bits[19:0], 20'hA3CA5);
      check("starve_en",   en_cnt,  20);
      check("starve_gap",  gap_cnt, 3);

      // Abort after 5 bits of 3C (0,0,1,1,1).
      do_start(1);
      push_word(8'h3C, 0);
      repeat (5) @(posedge prog_clk);
      #1;
      abort = 1'b1;
      @(posedge prog_clk); #1;
      abort = 1'b0;
      idle(6);
      check("abort_en",   en_cnt,        5);
      check("abort_bits", log_bits[4:0], 5'h1C);
      check("abort_done", done_cnt,      0);
      check("abort_busy", busy,          0);

      // start and abort together while idle: stay idle.
      @(posedge prog_clk); #1;
      start = 1'b1;
      abort = 1'b1;
      @(posedge prog_clk); #1;
      start = 1'b0;
      abort = 1'b0;
      idle(2);
      check("start_abort_busy", busy, 0);

      // Reload after abort starts again from bit 0.
      load3(8'hA5, 8'h3C, 8'hF6, 0);
      idle(2);
      check("reload_bits", log_bits[19:0], 20'h63CA5);
      check("reload_en",   en_cnt, 20);

      // Reset during the 9th enabled bit.
      do_start(1);
      push_word(8'hA5, 0);
      push_word(8'h3C, 0);
      @(posedge prog_clk); #1;
      prog_reset = 1'b1;
      @(posedge prog_clk); #1;
      prog_reset = 1'b0;
      idle(1);
      check("rstmid_en",    en_cnt,        9);
      check("rstmid_head",  ccff_head,     0);
      check("rstmid_shift", ccff_shift_en, 0);
      check("rstmid_busy",  busy,          0);
      check("rstmid_ready", cfg.cfg_ready, 0);
      load3(8'h5A, 8'hC3, 8'h09, 0);
      idle(2);
      check("rstmid_reload_bits", log_bits[19:0], 20'h9C35A);

`ifdef CCFF_READBACK_CRC_EN
      // Same pattern twice, then zeros: the readback CRC sees the previous
      // chain contents, i.e. the pattern.
      load3(8'hA5, 8'h3C, 8'hF6, 0);
      idle(1);
      check("crc_wr1", wr_crc, crc_model(32'h63CA5, 20));
      load3(8'hA5, 8'h3C, 8'hF6, 0);
      idle(1);
      check("crc_wr2", wr_crc, crc_model(32'h63CA5, 20));
      check("crc_rb2", rb_crc, crc_model(32'h63CA5, 20));
      load3(8'h00, 8'h00, 8'h00, 0);
      idle(2);
      check("crc_wr0", wr_crc, crc_model(32'h0, 20));
      check("crc_rb0", rb_crc, crc_model(32'h63CA5, 20));
`endif

      idle(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule : tb_ccff_chain_loader
